// File: rtl/uart_defs.sv
// Shared frame-format codes, FSM encodings and parity helper for the configurable UART.
// Latency: none (package only).
// Backpressure: n/a.
package uart_defs;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    typedef struct packed {
        logic [1:0] data_bits;
        logic [1:0] parity_mode;
        logic       stop2;
    } frame_cfg_t;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [3:0] num_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Only the low num_bits(code) bits of data take part in the parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] code,
                                        input logic [1:0] mode);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - code);
        return (^(data & mask)) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running baud tick generator: one-clk tick every dvsr+1 clks.
// Latency: tick decoded combinationally from the registered counter.
// Backpressure: none; always running.
module baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);
    logic [DVSR_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == dvsr);

    // >= so a divisor lowered below the current count wraps at once.
    always_comb begin
        cnt_d = (cnt_q >= dvsr) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo.sv
// Generic show-ahead FIFO, count-based full/empty, contents cleared on reset.
// Latency: written word visible at r_data one clk after the write; pop takes effect next clk.
// Backpressure: write accepted when not full or when a pop frees a slot; pop ignored when empty.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] r_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rd_en, wr_en;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL_CNT);
    assign rd_en  = rd & ~empty;
    assign wr_en  = wr & (~full | rd_en);
    assign r_data = mem_q[rptr_q];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            mem_d[wptr_q] = w_data;
            wptr_d        = wptr_q + 1'b1;
        end
        if (rd_en) rptr_d = rptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, oversampled RX FSM, parity/framing checks.
// Latency: entry pushed ~2 clk after the centre of the last stop bit.
// Backpressure: none; push is a one-clk strobe, the caller handles a full FIFO.
module uart_rx_cfg
    import uart_defs::*;
#(
    parameter int OS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       tick,
    input  logic [1:0] data_bits,
    input  logic [1:0] parity_mode,
    input  logic       stop2,
    output logic       push,
    output rx_entry_t  entry
);
    localparam int SW = $clog2(OS);
    localparam logic [SW-1:0] MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] LAST = SW'(OS - 1);

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  b_q, b_d;
    frame_cfg_t  cfg_q, cfg_d;
    logic        pbit_q, pbit_d;
    logic        fe_q, fe_d;

    logic        rx_s, fe_now, pe_calc;
    logic [3:0]  nbits_m1;
    logic [7:0]  data_rj;

    assign rx_s     = sync_q[1];
    assign fe_now   = fe_q | ~rx_s;
    assign nbits_m1 = num_bits(cfg_q.data_bits) - 4'd1;
    // Bits arrive at the MSB end; shift the frame down so it is right-justified.
    assign data_rj  = b_q >> (4'd8 - num_bits(cfg_q.data_bits));
    assign pe_calc  = parity_en(cfg_q.parity_mode) &
                      (pbit_q != parity_bit(data_rj, cfg_q.data_bits, cfg_q.parity_mode));
    assign entry    = '{fe: fe_now, pe: pe_calc, data: data_rj};

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        cfg_d   = cfg_q;
        pbit_d  = pbit_q;
        fe_d    = fe_q;
        push    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    s_d     = '0;
                    n_d     = '0;
                    fe_d    = 1'b0;
                    cfg_d   = '{data_bits: data_bits, parity_mode: parity_mode, stop2: stop2};
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (s_q == MID) begin
                        s_d     = '0;
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (s_q == LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[7:1]};
                        if ({1'b0, n_q} == nbits_m1) begin
                            n_d     = '0;
                            state_d = parity_en(cfg_q.parity_mode) ? RX_PARITY : RX_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (s_q == LAST) begin
                        s_d     = '0;
                        pbit_d  = rx_s;
                        state_d = RX_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (s_q == LAST) begin
                        s_d  = '0;
                        fe_d = fe_now;
                        if (n_q == {2'b00, cfg_q.stop2}) begin
                            push    = 1'b1;
                            n_d     = '0;
                            state_d = fe_now ? RX_WAIT_HIGH : RX_IDLE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            cfg_q   <= '0;
            pbit_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            cfg_q   <= cfg_d;
            pbit_q  <= pbit_d;
            fe_q    <= fe_d;
        end
    end
endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable full-duplex UART (5-8 data bits, none/even/odd parity, 1/2 stop bits).
// Latency: write into an idle empty TX FIFO drives the start bit after the next clk edge.
// Backpressure: wr_uart ignored while tx_full; rd_uart ignored while rx_empty; RX drops on full.
module uart_cfg
    import uart_defs::*;
#(
    parameter int OS     = 16,
    parameter int FIFO_W = 2,
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    input  logic              rd_uart,
    input  logic              err_clr,
    input  logic              rx,
    output logic              tx,
    output logic              tx_full,
    output logic              rx_empty,
    output logic [7:0]        r_data,
    output logic              r_pe,
    output logic              r_fe,
    output logic              overrun_err
);
    localparam int SW = $clog2(2 * OS);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OS - 1);
    localparam logic [SW-1:0] STOP2_LAST = SW'(2 * OS - 1);

    logic       tick;
    logic       tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_push, rx_full;
    rx_entry_t  rx_entry, rx_head;

    baud_gen #(.DVSR_W(DVSR_W)) u_baud (
        .clk   (clk),
        .reset (reset),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart & ~tx_full),
        .w_data (w_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .r_data (tx_head)
    );

    uart_rx_cfg #(.OS(OS)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .tick        (tick),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .push        (rx_push),
        .entry       (rx_entry)
    );

    fifo #(.DATA_WIDTH(10), .ADDR_WIDTH(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_push),
        .w_data (rx_entry),
        .empty  (rx_empty),
        .full   (rx_full),
        .r_data (rx_head)
    );

    assign r_data = rx_head.data;
    assign r_pe   = rx_head.pe;
    assign r_fe   = rx_head.fe;

    tx_state_e     state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          par_q, par_d;
    frame_cfg_t    cfg_q, cfg_d;
    logic          tx_q, tx_d;
    logic          ovr_q, ovr_d;
    logic [SW-1:0] stop_last;

    assign tx          = tx_q;
    assign overrun_err = ovr_q;
    assign stop_last   = cfg_q.stop2 ? STOP2_LAST : BIT_LAST;

    // A new overrun beats a simultaneous clear.
    assign ovr_d = (rx_push & rx_full & ~rd_uart) | (ovr_q & ~err_clr);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        cfg_d   = cfg_q;
        tx_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    b_d     = tx_head;
                    cfg_d   = '{data_bits: data_bits, parity_mode: parity_mode, stop2: stop2};
                    par_d   = parity_bit(tx_head, data_bits, parity_mode);
                    s_d     = '0;
                    n_d     = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = TX_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if ({1'b0, n_q} == num_bits(cfg_q.data_bits) - 4'd1) begin
                            n_d     = '0;
                            state_d = parity_en(cfg_q.parity_mode) ? TX_PARITY : TX_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = TX_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (s_q == stop_last) begin
                        s_d     = '0;
                        state_d = TX_IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // tx is decoded from the next state so the pin flop changes with the FSM.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = b_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            cfg_q   <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            cfg_q   <= cfg_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Runtime-configurable full-duplex UART, the successor to the fixed 8N1 UART top.
- Frame format is programmable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Adds per-byte parity/framing error reporting, a sticky overrun flag, parametrised FIFO depth and divisor width.
- Sits between the bus-side register interface and the pins.
- Reuses the existing baud_gen and fifo blocks.

Parameters:
OS, 16, oversampling ticks per bit
FIFO_W, 2, FIFO address width; depth = 2**FIFO_W per direction
DVSR_W, 11, width of baud divisor

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clk
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_mode  in  2  00=none, 01=even, 10=odd, 11=none (reserved)
stop2  in  1  1 = two stop bits
wr_uart  in  1  push w_data into TX FIFO
w_data  in  8  TX byte; bits above data_bits ignored
rd_uart  in  1  pop RX FIFO
err_clr  in  1  clear overrun_err
rx  in  1  serial input, asynchronous
tx  out  1  serial output, registered
tx_full  out  1  TX FIFO full
rx_empty  out  1  RX FIFO empty
r_data  out  8  RX head byte, right-justified, unused MSBs zero
r_pe  out  1  parity error flag of head entry
r_fe  out  1  framing error flag of head entry
overrun_err  out  1  sticky overrun

Behaviour:
Clocking and reset:
- Single clock domain.
- Asynchronous active-high reset forces: tx=1, tx_full=0, rx_empty=1, r_data/r_pe/r_fe=0 (FIFO contents cleared), overrun_err=0, both FSMs IDLE, tick counter 0.
- Reset mid-frame aborts the frame immediately; no partial byte is kept.

Baud tick:
- Counter runs 0..dvsr; tick=1 for one clk when counter==dvsr.
- dvsr=0 gives a tick every clk.

Config latch:
- data_bits, parity_mode and stop2 are latched when an FSM leaves IDLE.
- Changes mid-frame have no effect on the frame in flight.

RX input path:
- rx passes through a 2-flop synchroniser, reset value 1.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE with TX FIFO non-empty: latch FIFO head, pop TX FIFO, go to START, drive tx=0.
- A write on edge k into an empty FIFO while idle gives tx=0 after edge k+1.
- Every bit lasts exactly OS ticks; data is sent LSB first, n bits.
- PARITY is skipped when parity is none. Even parity: bit = XOR of data bits. Odd parity: its inverse.
- STOP drives 1 for OS ticks, or 2*OS if stop2.
- From STOP, return to IDLE; a back-to-back frame starts on the next clk.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- IDLE: on synchronised rx=0, clear tick count and go to START.
- START: at tick OS/2-1 sample rx. If 0, go to DATA; if 1 (glitch), go back to IDLE with no side effects.
- DATA and PARITY: sample every OS ticks thereafter.
- pe = received parity ≠ computed parity; pe is 0 when parity is none.
- STOP: sample each stop bit at its centre. fe=1 if any sampled stop bit is 0.
- Frame end: push {fe, pe, data} into the RX FIFO (10-bit entries).
- If fe=1, go to WAIT_HIGH and stay until rx=1 (break handling), then IDLE. Otherwise go to IDLE.

FIFOs:
- wr_uart while tx_full is ignored; rd_uart while rx_empty is ignored.
- RX push with rx_full and no rd_uart in the same clk: entry dropped, overrun_err set.
- RX push with rx_full and rd_uart in the same clk: both the push and the pop occur; no overrun.
- overrun_err clears on err_clr. If err_clr and a new overrun coincide, the flag stays set.

Decomposition:
- Shared header/package uart_defs: data_bits codes, parity_mode codes, TX/RX state encodings, a parity function.
- One new sub-module, uart_rx_cfg: synchroniser, RX FSM and error detection.
- TX FSM inline in uart_cfg.
- Reuse baud_gen (widened to DVSR_W) and fifo (TX DATA_WIDTH=8, RX DATA_WIDTH=10).

Test Plan:
All scenarios use dvsr=1, giving 32 clk per bit.
- 8N1 loopback: write 0xA5 → tx shows 0,1,0,1,0,0,1,0,1,1, each 32 clk → rx_empty falls, r_data=0xA5, r_pe=0, r_fe=0.
- 7E2: write 0x41 → parity bit 0, frame is 11 bits = 352 clk of activity, tx=1 for the final 64 clk → r_data=0x41, r_pe=0.
- 8O1 error injection: bench drives 0x00 with parity bit 0 → r_data=0x00, r_pe=1, r_fe=0.
- Framing error: 8N1 0x55 with stop bit held 0 and rx held low 200 clk → one entry with r_fe=1 and no second frame until rx returns high.
- Overrun (FIFO_W=2): five 8N1 frames received, no rd_uart → four entries kept, overrun_err=1; err_clr → overrun_err=0.
- Glitch and reset: rx low 4 clk → no entry. Assert reset 100 clk into a TX frame → tx=1 at once, tx_full=0, no byte is resent after release.
